classify_ctrl: RTL and testbench
================================

# classify_ctrl

Sequencer in front of the 10-way popcount comparator of the MNIST binary network. Collects the ten per-class popcounts that the XNOR/popcount stage produces serially (one class per beat, any order), presents them in parallel to the comparator with a one-cycle `valid_in` pulse, and waits for its `valid_out`. It then latches the winning index and confidence and holds them on a valid/ready result port for the host/readout logic.

## Interface
- `NUM_CLASSES`, 10: number of class popcounts per image; `pc_class` is 4 bits wide.
- `PC_W`, 9: popcount width.
- `TIMEOUT`, 15: maximum cycles spent in WAIT_CMP before the block aborts.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins collection for one image.
- `pc_valid`  in  1  popcount beat valid.
- `pc_class`  in  4  class index of the beat, 0..`NUM_CLASSES`-1.
- `pc_data`  in  `PC_W`  popcount value.
- `pc_ready`  out  1  beat is accepted when `pc_valid & pc_ready`.
- `cmp_valid_in`  out  1  one-cycle launch pulse to the comparator.
- `cmp_popcounts`  out  `NUM_CLASSES*PC_W`  class k occupies bits [k*PC_W +: PC_W]; drives `popcount_in_(k+1)`.
- `cmp_valid_out`  in  1  comparator result strobe.
- `cmp_max_index`  in  4  comparator winning index.
- `cmp_confidence`  in  8  comparator confidence.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.
- `res_index`  out  4  latched winning index.
- `res_confidence`  out  8  latched confidence.
- `res_error`  out  1  an out-of-range class was seen, or the comparator timed out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The FSM has five states: IDLE, COLLECT, LAUNCH, WAIT_CMP, OUTPUT.
- IDLE:
  - `pc_ready` is 0.
  - On `start`: go to COLLECT, and clear the 10-bit received mask and the error flag. Stored popcounts are not cleared.
- COLLECT:
  - `pc_ready` is 1.
  - For an accepted beat with `pc_class` < `NUM_CLASSES`: write `pc_data` to slot `pc_class` and set the mask bit.
  - A repeated class overwrites the slot; the mask is unchanged.
  - For `pc_class` >= `NUM_CLASSES`: drop the beat and set the sticky error flag.
  - When the mask becomes all ones (including the bit being written this cycle), go to LAUNCH.
- LAUNCH:
  - Assert `cmp_valid_in` for exactly one cycle.
  - `cmp_popcounts` is stable from LAUNCH until the next COLLECT write.
  - Go to WAIT_CMP and clear the timeout counter.
- WAIT_CMP:
  - On `cmp_valid_out`: latch `cmp_max_index` and `cmp_confidence`, then go to OUTPUT.
  - Otherwise increment the counter. When it reaches `TIMEOUT`, go to OUTPUT with `res_index`=4'hF, `res_confidence`=0 and the error flag set.
- OUTPUT:
  - `res_valid` is 1. `res_index`, `res_confidence` and `res_error` are held stable until `res_ready`.
  - On handshake: go to IDLE. If `start` is also high in that same cycle, go directly to COLLECT (mask and error cleared).
- `start` outside IDLE and the OUTPUT handshake cycle is ignored.
- `cmp_valid_out` outside WAIT_CMP is ignored.
- `pc_valid` outside COLLECT is ignored.
- `res_error` is the sticky error flag, presented in OUTPUT.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State goes to IDLE.
  - Outputs `pc_ready`, `cmp_valid_in`, `res_valid`, `res_error`, `busy` are 0.
  - `res_index`=0, `res_confidence`=0, `cmp_popcounts`=0; mask, counter and slots are cleared.
- Reset mid-operation abandons the image; no `cmp_valid_in` or `res_valid` is produced.
- All outputs are registered.
- `start` in cycle N: `pc_ready`=1 and `busy`=1 in cycle N+1.
- Last missing class accepted in cycle N: `cmp_valid_in`=1 in cycle N+1, `pc_ready`=0 from N+1.
- `cmp_valid_out` in cycle M: `res_valid`=1 in cycle M+1.
- Timeout: `res_valid` rises `TIMEOUT`+1 cycles after the first WAIT_CMP cycle.
- Minimum image cycle (start, 10 beats, 1-cycle comparator, immediate `res_ready`): 14 cycles.

## Structure
- Shared package (`bnn_pkg`):
  - constants `NUM_CLASSES`, `PC_W`, `IDX_W`=4, `CONF_W`=8;
  - state enum encoding;
  - the error index value 4'hF.
- Sub-module `class_buffer`: the slot register file plus the received mask. It has inputs write-enable, class, data and clear, and outputs the `full` flag and the flattened popcount bus.
- The FSM, timeout counter and result registers live in `classify_ctrl`.

## Test plan
- Reset, `start`, classes 0..9 in order with values 100 except class 4 = 250; comparator model returns index 4, confidence C → `cmp_valid_in` is a single pulse one cycle after the last beat, and the bus carries all ten values; `res_index`=4, `res_confidence`=C, `res_error`=0.
- Classes sent in order 9,3,0,7,1,8,2,6,4,5 with a gap cycle between beats, class 3 sent twice (200 then 360) → slot 3 = 360, and launch happens only after class 5 arrives.
- A beat with `pc_class`=12 during COLLECT, then the valid set → the beat is dropped, launch happens normally, `res_error`=1.
- Comparator never asserts `cmp_valid_out` → `res_valid` arrives after `TIMEOUT`+1 WAIT_CMP cycles with `res_index`=4'hF, `res_confidence`=0, `res_error`=1.
- `res_ready` held low for 5 cycles, with stray `start` and `cmp_valid_out` pulses → result is stable and unchanged; then `res_ready` and `start` in the same cycle → the next cycle is COLLECT.
- `rst_n` asserted asynchronously after 6 beats → all outputs go to 0 immediately; after release the block is IDLE, and a full new image classifies correctly.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the MNIST BNN classification sequencer.
package bnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int PC_W        = 9;
    localparam int IDX_W       = 4;
    localparam int CONF_W      = 8;

    // Index reported when the comparator never answers.
    localparam logic [IDX_W-1:0] ERR_INDEX = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_LAUNCH   = 3'd2,
        S_WAIT_CMP = 3'd3,
        S_OUTPUT   = 3'd4
    } state_t;

endpackage

// File: rtl/class_buffer.sv
// Per-class popcount slots plus the mask of classes received for the current image.
module class_buffer #(
    parameter int NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter int PC_W        = bnn_pkg::PC_W,
    parameter int IDX_W       = bnn_pkg::IDX_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_class,
    input  logic [PC_W-1:0]             wr_data,
    output logic                        full,
    output logic [NUM_CLASSES*PC_W-1:0] popcounts
);

    logic [NUM_CLASSES-1:0] mask_q;
    logic [NUM_CLASSES-1:0] wr_sel;
    logic [PC_W-1:0]        slot_q [NUM_CLASSES];

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            wr_sel[k] = wr_en && (wr_class == IDX_W'(k));
        end
    end

    // Counts the beat being written this cycle so the launch is not delayed a cycle.
    assign full = &(mask_q | wr_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (clr) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_q | wr_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (wr_sel[k]) begin
                    slot_q[k] <= wr_data;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_flat
        assign popcounts[k*PC_W +: PC_W] = slot_q[k];
    end

endmodule

// File: rtl/classify_ctrl.sv
// Collects serial per-class popcounts, launches the 10-way comparator and holds its result.
module classify_ctrl #(
    parameter int NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter int PC_W        = bnn_pkg::PC_W,
    parameter int TIMEOUT     = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         pc_valid,
    input  logic [bnn_pkg::IDX_W-1:0]    pc_class,
    input  logic [PC_W-1:0]              pc_data,
    output logic                         pc_ready,
    output logic                         cmp_valid_in,
    output logic [NUM_CLASSES*PC_W-1:0]  cmp_popcounts,
    input  logic                         cmp_valid_out,
    input  logic [bnn_pkg::IDX_W-1:0]    cmp_max_index,
    input  logic [bnn_pkg::CONF_W-1:0]   cmp_confidence,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [bnn_pkg::IDX_W-1:0]    res_index,
    output logic [bnn_pkg::CONF_W-1:0]   res_confidence,
    output logic                         res_error,
    output logic                         busy
);

    import bnn_pkg::*;

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             class_ok;
    logic             buf_wr;
    logic             buf_clr;
    logic             buf_full;
    logic             restart;

    assign class_ok = int'(pc_class) < NUM_CLASSES;
    assign buf_wr   = (state == S_COLLECT) && pc_valid && class_ok;
    assign restart  = ((state == S_IDLE) && start) ||
                      ((state == S_OUTPUT) && res_ready && start);
    assign buf_clr  = restart;

    class_buffer #(
        .NUM_CLASSES (NUM_CLASSES),
        .PC_W        (PC_W),
        .IDX_W       (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (buf_clr),
        .wr_en     (buf_wr),
        .wr_class  (pc_class),
        .wr_data   (pc_data),
        .full      (buf_full),
        .popcounts (cmp_popcounts)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc_ready       <= 1'b0;
            cmp_valid_in   <= 1'b0;
            res_valid      <= 1'b0;
            res_error      <= 1'b0;
            res_index      <= '0;
            res_confidence <= '0;
            busy           <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            cmp_valid_in <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_COLLECT;
                        pc_ready <= 1'b1;
                        busy     <= 1'b1;
                        err_q    <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (pc_valid) begin
                        if (!class_ok) begin
                            err_q <= 1'b1;
                        end else if (buf_full) begin
                            state        <= S_LAUNCH;
                            pc_ready     <= 1'b0;
                            cmp_valid_in <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT_CMP;
                    cnt_q <= '0;
                end
                S_WAIT_CMP: begin
                    if (cmp_valid_out) begin
                        state          <= S_OUTPUT;
                        res_valid      <= 1'b1;
                        res_index      <= cmp_max_index;
                        res_confidence <= cmp_confidence;
                        res_error      <= err_q;
                    end else if (cnt_q == CNT_MAX) begin
                        // Comparator never answered: report a flagged dummy result.
                        state          <= S_OUTPUT;
                        res_valid      <= 1'b1;
                        res_index      <= ERR_INDEX;
                        res_confidence <= '0;
                        res_error      <= 1'b1;
                        err_q          <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_error <= 1'b0;
                        if (start) begin
                            state    <= S_COLLECT;
                            pc_ready <= 1'b1;
                            err_q    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    pc_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_classify_ctrl.sv
// Directed table-driven and sequence bench for classify_ctrl.
module tb_classify_ctrl;

    localparam int NC = 10;
    localparam int PW = 9;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            pc_valid;
    logic [3:0]      pc_class;
    logic [PW-1:0]   pc_data;
    logic            pc_ready;
    logic            cmp_valid_in;
    logic [NC*PW-1:0] cmp_popcounts;
    logic            cmp_valid_out;
    logic [3:0]      cmp_max_index;
    logic [7:0]      cmp_confidence;
    logic            res_valid;
    logic            res_ready;
    logic [3:0]      res_index;
    logic [7:0]      res_confidence;
    logic            res_error;
    logic            busy;

    int nchk = 0;
    int nerr = 0;
    logic cmp_auto = 1'b1;
    logic cmp_pend = 1'b0;
    logic [NC*PW-1:0] exp_bus;

    classify_ctrl #(.NUM_CLASSES(NC), .PC_W(PW), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pc_valid       (pc_valid),
        .pc_class       (pc_class),
        .pc_data        (pc_data),
        .pc_ready       (pc_ready),
        .cmp_valid_in   (cmp_valid_in),
        .cmp_popcounts  (cmp_popcounts),
        .cmp_valid_out  (cmp_valid_out),
        .cmp_max_index  (cmp_max_index),
        .cmp_confidence (cmp_confidence),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_index      (res_index),
        .res_confidence (res_confidence),
        .res_error      (res_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       pv;
        logic [3:0] cls;
        logic [8:0] dat;
        logic       rdy;
        logic [3:0] e_flags;   // {pc_ready, cmp_valid_in, res_valid, busy}
        logic [3:0] e_idx;
        logic [7:0] e_conf;
        logic       e_err;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Comparator model: answers one cycle after the launch pulse is seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cmp_auto) begin
            cmp_valid_out = cmp_pend;
            cmp_pend      = cmp_valid_in;
        end
    endtask

    task automatic send(input logic [3:0] cls, input logic [8:0] dat);
        pc_valid = 1'b1;
        pc_class = cls;
        pc_data  = dat;
        tick();
        pc_valid = 1'b0;
    endtask

    task automatic wait_res(input int max_cyc, input string name);
        int n;
        n = 0;
        while (!res_valid && n < max_cyc) begin
            tick();
            n++;
        end
        check({name, "_res_valid"}, res_valid, 1'b1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; pc_valid = 1'b0; pc_class = '0; pc_data = '0;
        cmp_valid_out = 1'b0; cmp_max_index = '0; cmp_confidence = '0; res_ready = 1'b0;

        // Test 1 vectors: ten classes in order, class 4 wins.
        tbl[0] = '{1'b1, 1'b0, 4'd0, 9'd0, 1'b0, 4'b1001, 4'd0, 8'd0, 1'b0};
        for (int k = 0; k < 10; k++) begin
            tbl[k+1] = '{1'b0, 1'b1, 4'(k), (k == 4) ? 9'd250 : 9'd100, 1'b0,
                         (k == 9) ? 4'b0101 : 4'b1001, 4'd0, 8'd0, 1'b0};
        end
        tbl[11] = '{1'b0, 1'b0, 4'd0, 9'd0, 1'b0, 4'b0001, 4'd0, 8'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'd0, 9'd0, 1'b0, 4'b0011, 4'd4, 8'd77, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'd0, 9'd0, 1'b1, 4'b0000, 4'd0, 8'd0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {pc_ready, cmp_valid_in, res_valid, busy, res_error}, 5'b0);
        check("reset_data", {res_index, res_confidence, cmp_popcounts}, '0);
        rst_n = 1'b1;
        tick();

        // Test 1
        cmp_max_index = 4'd4; cmp_confidence = 8'd77;
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].start; pc_valid = tbl[i].pv; pc_class = tbl[i].cls;
            pc_data = tbl[i].dat; res_ready = tbl[i].rdy;
            tick();
            start = 1'b0; pc_valid = 1'b0; res_ready = 1'b0;
            check($sformatf("t1_flags_row%0d", i), {pc_ready, cmp_valid_in, res_valid, busy}, tbl[i].e_flags);
            if (tbl[i].e_flags[1]) begin
                check($sformatf("t1_res_row%0d", i), {res_index, res_confidence, res_error},
                      {tbl[i].e_idx, tbl[i].e_conf, tbl[i].e_err});
            end
        end
        for (int k = 0; k < 10; k++) exp_bus[k*PW +: PW] = (k == 4) ? 9'd250 : 9'd100;
        check("t1_bus", cmp_popcounts, exp_bus);

        // Test 2: scrambled order with gaps, class 3 repeated
        begin
            int ord[11] = '{9, 3, 0, 7, 1, 8, 2, 6, 4, 3, 5};
            logic [8:0] d;
            logic seen3;
            seen3 = 1'b0;
            cmp_max_index = 4'd3; cmp_confidence = 8'd200;
            start = 1'b1; tick(); start = 1'b0;
            for (int i = 0; i < 11; i++) begin
                if (ord[i] == 3) begin
                    d = seen3 ? 9'd360 : 9'd200;
                    seen3 = 1'b1;
                end else begin
                    d = 9'(ord[i] * 10 + 5);
                end
                send(4'(ord[i]), d);
                if (i < 10) begin
                    check($sformatf("t2_no_launch_%0d", i), {pc_ready, cmp_valid_in}, 2'b10);
                    tick();
                end else begin
                    check("t2_launch", {pc_ready, cmp_valid_in}, 2'b01);
                end
            end
            for (int k = 0; k < 10; k++) exp_bus[k*PW +: PW] = (k == 3) ? 9'd360 : 9'(k * 10 + 5);
            check("t2_slot3", cmp_popcounts[3*PW +: PW], 9'd360);
            check("t2_bus", cmp_popcounts, exp_bus);
            wait_res(5, "t2");
            check("t2_res", {res_index, res_confidence, res_error}, {4'd3, 8'd200, 1'b0});
            handshake();
        end

        // Test 3: out-of-range class dropped, error reported
        cmp_max_index = 4'd6; cmp_confidence = 8'd33;
        start = 1'b1; tick(); start = 1'b0;
        send(4'd12, 9'd55);
        check("t3_after_bad", {pc_ready, cmp_valid_in, busy}, 3'b101);
        for (int k = 0; k < 10; k++) send(4'(k), 9'(20 + k));
        check("t3_launch", cmp_valid_in, 1'b1);
        for (int k = 0; k < 10; k++) exp_bus[k*PW +: PW] = 9'(20 + k);
        check("t3_bus", cmp_popcounts, exp_bus);
        wait_res(5, "t3");
        check("t3_res", {res_index, res_confidence, res_error}, {4'd6, 8'd33, 1'b1});
        handshake();

        // Test 4: comparator silent -> timeout
        cmp_auto = 1'b0; cmp_valid_out = 1'b0; cmp_pend = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 10; k++) send(4'(k), 9'(40 + k));
        check("t4_launch", cmp_valid_in, 1'b1);
        tick();
        for (int i = 0; i < TMO; i++) tick();
        check("t4_not_yet", res_valid, 1'b0);
        tick();
        check("t4_res_valid", res_valid, 1'b1);
        check("t4_res", {res_index, res_confidence, res_error}, {4'hF, 8'd0, 1'b1});

        // Test 5: held result with stray start / cmp_valid_out, then ready+start
        cmp_max_index = 4'd2; cmp_confidence = 8'd9;
        for (int i = 0; i < 5; i++) begin
            start = (i == 1);
            cmp_valid_out = (i == 3);
            tick();
            start = 1'b0; cmp_valid_out = 1'b0;
            check($sformatf("t5_hold_%0d", i), {res_valid, busy, res_index, res_confidence, res_error},
                  {1'b1, 1'b1, 4'hF, 8'd0, 1'b1});
        end
        res_ready = 1'b1; start = 1'b1;
        tick();
        res_ready = 1'b0; start = 1'b0;
        check("t5_restart", {pc_ready, busy, res_valid, res_error}, 4'b1100);

        // Test 6: asynchronous reset mid-collection, then a clean image
        cmp_auto = 1'b1; cmp_pend = 1'b0; cmp_valid_out = 1'b0;
        for (int k = 0; k < 6; k++) send(4'(k), 9'(300 + k));
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_flags", {pc_ready, cmp_valid_in, res_valid, res_error, busy}, 5'b0);
        check("t6_async_data", {res_index, res_confidence, cmp_popcounts}, '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        tick();
        check("t6_idle", {pc_ready, cmp_valid_in, res_valid, busy}, 4'b0);
        cmp_max_index = 4'd7; cmp_confidence = 8'd150;
        start = 1'b1; tick(); start = 1'b0;
        check("t6_collect", {pc_ready, busy}, 2'b11);
        for (int k = 0; k < 10; k++) send(4'(k), (k == 7) ? 9'd480 : 9'(30 + k * 7));
        check("t6_launch", cmp_valid_in, 1'b1);
        for (int k = 0; k < 10; k++) exp_bus[k*PW +: PW] = (k == 7) ? 9'd480 : 9'(30 + k * 7);
        check("t6_bus", cmp_popcounts, exp_bus);
        wait_res(5, "t6");
        check("t6_res", {res_index, res_confidence, res_error}, {4'd7, 8'd150, 1'b0});
        handshake();
        check("t6_done", {res_valid, busy}, 2'b00);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
